// File: rtl/div_seq_16.sv
// rtl/div_seq_16.sv - sequential restoring divider, 2N-bit dividend by N-bit divisor
//
// Purpose:
//   Divides an unsigned 2N-bit dividend by an unsigned N-bit divisor and
//   produces one quotient bit per clock. It flags divide-by-zero and quotient
//   overflow, which is when the quotient does not fit in N bits.
//
// Ports:
//   clk        in   1    rising-edge clock
//   rst        in   1    asynchronous, active-high reset
//   start      in   1    request; sampled only while idle
//   dividend   in   2N   numerator, captured when start is accepted
//   divisor    in   N    denominator, captured when start is accepted
//   busy       out  1    high whenever the FSM is not idle
//   done       out  1    one-cycle pulse; results are valid from this cycle on
//   quotient   out  N    registered quotient (all ones on error)
//   remainder  out  N    registered remainder (zero on error)
//   div_zero   out  1    divisor was zero
//   ovf        out  1    dividend[2N-1:N] >= divisor (also set on divide-by-zero)

module div_seq_16 #(
  parameter int N = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [2*N-1:0] dividend,
  input  logic [N-1:0]   divisor,
  output logic           busy,
  output logic           done,
  output logic [N-1:0]   quotient,
  output logic [N-1:0]   remainder,
  output logic           div_zero,
  output logic           ovf
);

  localparam int CW = (N > 2) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    rem_q, rem_d;
  logic [N-1:0]    q_q, q_d;
  logic [N-1:0]    dvs_q, dvs_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  // The error path takes one DONE cycle with this flag set, then the pulse cycle.
  // That gives it a two-cycle latency while the FSM keeps only three states.
  logic            err_pend_q, err_pend_d;
  logic            err_dz_q, err_dz_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [N-1:0]    quotient_q, quotient_d;
  logic [N-1:0]    remainder_q, remainder_d;
  logic            div_zero_q, div_zero_d;
  logic            ovf_q, ovf_d;

  // One restoring step.
  // The compare is N+1 bits wide, so the bit shifted out of rem is never lost.
  // The difference is always below the divisor, so N bits of the subtractor are enough.
  logic [N:0]      trial;
  logic            qbit;
  logic [N-1:0]    rem_step;
  logic [N-1:0]    q_step;

  always_comb begin
    trial    = {rem_q, q_q[N-1]};
    qbit     = (trial >= {1'b0, dvs_q});
    rem_step = qbit ? (trial[N-1:0] - dvs_q) : trial[N-1:0];
    q_step   = {q_q[N-2:0], qbit};
  end

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    q_d         = q_q;
    dvs_d       = dvs_q;
    cnt_d       = cnt_q;
    err_pend_d  = err_pend_q;
    err_dz_d    = err_dz_q;
    done_d      = 1'b0;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    div_zero_d  = div_zero_q;
    ovf_d       = ovf_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          dvs_d = divisor;
          if ((divisor == '0) || (dividend[2*N-1:N] >= divisor)) begin
            state_d    = DONE;
            err_pend_d = 1'b1;
            err_dz_d   = (divisor == '0);
          end else begin
            state_d = CALC;
            rem_d   = dividend[2*N-1:N];
            q_d     = dividend[N-1:0];
            cnt_d   = CW'(N - 1);
          end
        end
      end

      CALC: begin
        rem_d = rem_step;
        q_d   = q_step;
        if (cnt_q == '0) begin
          state_d     = DONE;
          done_d      = 1'b1;
          quotient_d  = q_step;
          remainder_d = rem_step;
          div_zero_d  = 1'b0;
          ovf_d       = 1'b0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      DONE: begin
        if (err_pend_q) begin
          err_pend_d  = 1'b0;
          done_d      = 1'b1;
          quotient_d  = '1;
          remainder_d = '0;
          div_zero_d  = err_dz_q;
          ovf_d       = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      q_q         <= '0;
      dvs_q       <= '0;
      cnt_q       <= '0;
      err_pend_q  <= 1'b0;
      err_dz_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      div_zero_q  <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      q_q         <= q_d;
      dvs_q       <= dvs_d;
      cnt_q       <= cnt_d;
      err_pend_q  <= err_pend_d;
      err_dz_q    <= err_dz_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      div_zero_q  <= div_zero_d;
      ovf_q       <= ovf_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign div_zero  = div_zero_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_div_seq_16.sv
// tb/tb_div_seq_16.sv - directed and seeded-random bench for div_seq_16

module tb_div_seq_16;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] dividend;
  logic [15:0] divisor;
  logic        busy;
  logic        done;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        div_zero;
  logic        ovf;

  int n_vec;
  int n_bad;

  div_seq_16 #(.N(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Applies one division and checks latency, results, flags and the done pulse.
  // It also checks that busy and all outputs stay stable until done.
  // hold_start keeps start high through the whole operation, so a queued request would show.
  task automatic run_div(input string tag, input logic [31:0] dvd, input logic [15:0] dvs,
                         input logic [15:0] eq, input logic [15:0] er,
                         input logic edz, input logic eovf, input int elat,
                         input bit hold_start);
    logic [15:0] pq, pr;
    logic        pdz, povf;
    bit          stable;
    int          lat;
    @(negedge clk);
    pq = quotient; pr = remainder; pdz = div_zero; povf = ovf;
    stable   = 1'b1;
    dividend = dvd;
    divisor  = dvs;
    start    = 1'b1;
    @(negedge clk);
    lat = 1;
    if (!hold_start) start = 1'b0;
    dividend = $urandom;
    divisor  = 16'($urandom);
    while (done !== 1'b1 && lat < 40) begin
      if (busy !== 1'b1 || quotient !== pq || remainder !== pr ||
          div_zero !== pdz || ovf !== povf) stable = 1'b0;
      @(negedge clk);
      lat++;
    end
    chk({tag, ":latency"}, 64'(lat), 64'(elat));
    chk({tag, ":stable"}, 64'(stable), 64'd1);
    chk({tag, ":quotient"}, 64'(quotient), 64'(eq));
    chk({tag, ":remainder"}, 64'(remainder), 64'(er));
    chk({tag, ":flags"}, {62'd0, div_zero, ovf}, {62'd0, edz, eovf});
    chk({tag, ":busy_at_done"}, 64'(busy), 64'd1);
    @(negedge clk);
    start = 1'b0;
    chk({tag, ":done_width"}, 64'(done), 64'd0);
    chk({tag, ":idle_after"}, 64'(busy), 64'd0);
    chk({tag, ":hold"}, {32'd0, quotient, remainder}, {32'd0, eq, er});
  endtask

  initial begin
    logic [31:0] rd;
    logic [15:0] rs;
    bit          seen_done;
    n_vec = 0;
    n_bad = 0;
    rst = 1'b1;
    start = 1'b0;
    dividend = '0;
    divisor = '0;
    #12;
    chk("reset:outputs", {28'd0, busy, done, div_zero, ovf, quotient, remainder}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    run_div("t1_exact", 32'h27F86EE9, 16'hD431, 16'h3039, 16'h0000, 1'b0, 1'b0, 17, 1'b0);
    run_div("t2_rem7", 32'h27F86EF0, 16'hD431, 16'h3039, 16'h0007, 1'b0, 1'b0, 17, 1'b1);
    run_div("t3_max", 32'hFFFE0001, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 17, 1'b0);
    run_div("t4_divzero", 32'h00001234, 16'h0000, 16'hFFFF, 16'h0000, 1'b1, 1'b1, 2, 1'b0);
    run_div("t5_ovf", 32'h00010000, 16'h0001, 16'hFFFF, 16'h0000, 1'b0, 1'b1, 2, 1'b1);
    run_div("small", 32'd100, 16'd7, 16'd14, 16'd2, 1'b0, 1'b0, 17, 1'b0);
    run_div("ovf_equal", 32'h12340000, 16'h1234, 16'hFFFF, 16'h0000, 1'b0, 1'b1, 2, 1'b0);
    run_div("max_rem", 32'hFFFEFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b0, 1'b0, 17, 1'b0);
    run_div("zero_num", 32'h00000000, 16'h0005, 16'h0000, 16'h0000, 1'b0, 1'b0, 17, 1'b0);
    run_div("mid", 32'h0000FFFF, 16'h0100, 16'h00FF, 16'h00FF, 1'b0, 1'b0, 17, 1'b0);

    // Reset in the middle of a calculation, after an ignored second start.
    @(negedge clk);
    dividend = 32'h27F86EE9;
    divisor  = 16'hD431;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("t6:busy_mid", {62'd0, busy, done}, 64'd2);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t6:reset_outputs", {28'd0, busy, done, div_zero, ovf, quotient, remainder}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    seen_done = 1'b0;
    repeat (25) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) seen_done = 1'b1;
    end
    chk("t6:no_done", 64'(seen_done), 64'd0);
    run_div("t6_after", 32'h27F86EF0, 16'hD431, 16'h3039, 16'h0007, 1'b0, 1'b0, 17, 1'b0);

    for (int i = 0; i < 40; i++) begin
      rs = 16'($urandom);
      if (i % 10 == 3) rs = 16'h0000;
      rd = $urandom;
      if (i % 5 != 0 && rs != 16'h0000) rd[31:16] = 16'($urandom_range(int'(rs) - 1, 0));
      if (rs == 16'h0000 || rd[31:16] >= rs)
        run_div("rand_err", rd, rs, 16'hFFFF, 16'h0000, rs == 16'h0000, 1'b1, 2, i[0]);
      else
        run_div("rand", rd, rs, 16'(rd / {16'd0, rs}), 16'(rd % {16'd0, rs}), 1'b0, 1'b0, 17, i[0]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
